instr_mem_loader: RTL and testbench

//  Bus-side writer for the byte-serial instruction memory load port.

---
 rtl/instr_mem_loader_pkg.sv | 28 ++
 rtl/instr_mem_loader_strobe_timer.sv | 27 ++
 rtl/instr_mem_loader.sv | 178 +++++++++++++++++
 tb/tb_instr_mem_loader.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the byte-serial instruction memory loader:
// FSM state encoding, byte-select constants and the default memory depth.
package instr_mem_loader_pkg;

  localparam int DEPTH_DEF = 64;

  localparam logic BYTE_HI = 1'b1;
  localparam logic BYTE_LO = 1'b0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_WORD,
    S_SETUP_HI,
    S_STROBE_HI,
    S_GAP_HI,
    S_SETUP_LO,
    S_STROBE_LO,
    S_GAP_LO,
    S_DONE
  } state_t;

  // Pick the high or low byte of an instruction word.
  function automatic logic [7:0] byte_sel(input logic [15:0] w, input logic sel);
    return (sel == BYTE_HI) ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/instr_mem_loader_strobe_timer.sv
// Loadable down-counter used to time the clear, setup and gap intervals.
// Loading N-1 on entry to a state makes tc rise in the N-th cycle of it.
module strobe_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/instr_mem_loader.sv
// Bus-side writer for the byte-serial instruction memory load port.
// Accepts 16-bit words on a valid/ready stream and replays each one as two
// timed byte strobes (high byte first) after clearing the memory pointer.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int CNT_W     = 7,
  parameter int SETUP_CYC = 2,
  parameter int GAP_CYC   = 2,
  parameter int CLR_CYC   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] load_count,
  input  logic [15:0]      word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             mem_reset,
  output logic [7:0]       instruction,
  output logic             button,
  output logic             busy,
  output logic             done,
  output logic             err_count,
  output logic [CNT_W-1:0] words_sent
);

  localparam int               TMR_W    = 8;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] CLR_LD   = TMR_W'(CLR_CYC - 1);
  localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC - 1);

  state_t           state;
  logic [15:0]      word_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] sent_inc;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_tc;

  assign sent_inc = words_sent + CNT_W'(1);

  strobe_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // Arm the interval timer on every transition into a timed state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      S_IDLE: begin
        if (start && (load_count != '0)) begin
          tmr_load = 1'b1;
          tmr_val  = CLR_LD;
        end
      end
      S_WAIT_WORD: begin
        if (word_valid && word_ready) begin
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      S_STROBE_HI, S_STROBE_LO: begin
        tmr_load = 1'b1;
        tmr_val  = GAP_LD;
      end
      S_GAP_HI: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      default: ;
    endcase
  end

  // Load sequencer; every output is registered alongside the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      word_q      <= '0;
      count_q     <= '0;
      word_ready  <= 1'b0;
      mem_reset   <= 1'b0;
      instruction <= '0;
      button      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_count   <= 1'b0;
      words_sent  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            err_count  <= (load_count > DEPTH_C);
            count_q    <= (load_count > DEPTH_C) ? DEPTH_C : load_count;
            words_sent <= '0;
            busy       <= 1'b1;
            if (load_count == '0) begin
              state <= S_DONE;
            end else begin
              mem_reset <= 1'b1;
              state     <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          if (tmr_tc) begin
            mem_reset  <= 1'b0;
            word_ready <= 1'b1;
            state      <= S_WAIT_WORD;
          end
        end
        S_WAIT_WORD: begin
          if (word_valid && word_ready) begin
            word_q      <= word_in;
            instruction <= byte_sel(word_in, BYTE_HI);
            word_ready  <= 1'b0;
            state       <= S_SETUP_HI;
          end
        end
        S_SETUP_HI: begin
          if (tmr_tc) begin
            button <= 1'b1;
            state  <= S_STROBE_HI;
          end
        end
        S_STROBE_HI: begin
          button <= 1'b0;
          state  <= S_GAP_HI;
        end
        S_GAP_HI: begin
          if (tmr_tc) begin
            instruction <= byte_sel(word_q, BYTE_LO);
            state       <= S_SETUP_LO;
          end
        end
        S_SETUP_LO: begin
          if (tmr_tc) begin
            button <= 1'b1;
            state  <= S_STROBE_LO;
          end
        end
        S_STROBE_LO: begin
          button <= 1'b0;
          state  <= S_GAP_LO;
        end
        S_GAP_LO: begin
          if (tmr_tc) begin
            words_sent <= sent_inc;
            if (sent_inc < count_q) begin
              word_ready <= 1'b1;
              state      <= S_WAIT_WORD;
            end else begin
              instruction <= '0;
              state       <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: stimulus queues expected bytes and
// completion records; a negedge monitor pops and compares them, and models
// the receiving instruction memory.
module tb_instr_mem_loader;

  localparam int CNT_W     = 7;
  localparam int SETUP_CYC = 2;
  localparam int CLR_CYC   = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] load_count;
  logic [15:0]      word_in = 16'h0;
  logic             word_valid = 1'b0;
  logic             word_ready;
  logic             mem_reset;
  logic [7:0]       instruction;
  logic             button;
  logic             busy;
  logic             done;
  logic             err_count;
  logic [CNT_W-1:0] words_sent;

  instr_mem_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .load_count  (load_count),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .mem_reset   (mem_reset),
    .instruction (instruction),
    .button      (button),
    .busy        (busy),
    .done        (done),
    .err_count   (err_count),
    .words_sent  (words_sent)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // scoreboard queues
  logic [15:0] src_q[$];
  logic [7:0]  exp_bytes[$];
  int          exp_ws[$];
  int          exp_err[$];

  // monitor / memory model state
  logic [15:0] mem [0:127];
  int          ptr = 0;
  bit          hi_phase = 1'b1;
  logic [7:0]  hi_b = 8'h0;
  int          strobe_cnt = 0;
  int          done_cnt = 0;
  int          clr_seen = 0;
  int          clr_run = 0;
  int          last_clr_len = 0;
  int          stable_cnt = 0;
  logic [7:0]  prev_instr = 8'h0;
  logic        prev_button = 1'b0;
  bit          stall = 1'b0;
  bit          took = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Source: presents queued words, pops one after each completed handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (took && src_q.size() > 0) void'(src_q.pop_front());
      word_valid = !stall && (src_q.size() > 0);
      word_in    = word_valid ? src_q[0] : 16'h0;
      took       = word_valid && word_ready && !reset;
    end
  end

  // Monitor: strobe bytes, timing invariants, memory model, completion.
  always @(negedge clk) begin
    if (reset) hi_phase = 1'b1;
    if (instruction == prev_instr) stable_cnt++;
    else stable_cnt = 1;
    prev_instr = instruction;

    if (mem_reset) begin
      ptr = 0;
      hi_phase = 1'b1;
      clr_seen++;
      clr_run++;
    end else begin
      if (clr_run > 0) last_clr_len = clr_run;
      clr_run = 0;
    end

    if (button) begin
      strobe_cnt++;
      chk("strobe_isolated", {31'b0, prev_button}, 32'd0);
      chk("strobe_vs_mem_reset", {31'b0, mem_reset}, 32'd0);
      chk("setup_stable", {31'b0, stable_cnt >= SETUP_CYC + 1}, 32'd1);
      if (exp_bytes.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got byte %0h expected no strobe", instruction);
      end else begin
        chk("strobe_byte", {24'b0, instruction}, {24'b0, exp_bytes.pop_front()});
      end
      if (hi_phase) begin
        hi_b = instruction;
        hi_phase = 1'b0;
      end else begin
        if (ptr < 128) mem[ptr] = {hi_b, instruction};
        ptr++;
        hi_phase = 1'b1;
      end
    end
    prev_button = button;

    if (done) begin
      done_cnt++;
      if (exp_ws.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got words_sent %0d expected no done", words_sent);
      end else begin
        chk("done_words_sent", {25'b0, words_sent}, exp_ws.pop_front());
        chk("done_err_count", {31'b0, err_count}, exp_err.pop_front());
      end
    end
  end

  task automatic queue_words(input int n, input logic [15:0] base, input logic [15:0] step);
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      w = base + 16'(i) * step;
      src_q.push_back(w);
      exp_bytes.push_back(w[15:8]);
      exp_bytes.push_back(w[7:0]);
    end
  endtask

  task automatic pulse_start(input int n);
    @(negedge clk);
    start = 1'b1;
    load_count = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
    load_count = '0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt > d0) return;
    end
    chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, c0, bad_btn, bad_rdy;
    bit ok;
    logic [15:0] w;
    reset = 1'b1;
    start = 1'b0;
    load_count = '0;
    repeat (3) @(negedge clk);
    #1;
    // reset state
    chk("rst_mem_reset", {31'b0, mem_reset}, 32'd0);
    chk("rst_instruction", {24'b0, instruction}, 32'd0);
    chk("rst_button", {31'b0, button}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err_count}, 32'd0);
    chk("rst_words_sent", {25'b0, words_sent}, 32'd0);
    chk("rst_word_ready", {31'b0, word_ready}, 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;

    // 1: two words, bytes 42 01 42 41
    s0 = strobe_cnt; d0 = done_cnt;
    src_q.push_back(16'h4201); src_q.push_back(16'h4241);
    exp_bytes.push_back(8'h42); exp_bytes.push_back(8'h01);
    exp_bytes.push_back(8'h42); exp_bytes.push_back(8'h41);
    exp_ws.push_back(2); exp_err.push_back(0);
    pulse_start(2);
    #1 chk("t1_busy_after_start", {31'b0, busy}, 32'd1);
    wait_done(d0, 300, "t1");
    chk("t1_busy_at_done", {31'b0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    #1;
    chk("t1_strobes", strobe_cnt - s0, 32'd4);
    chk("t1_clr_len", last_clr_len, CLR_CYC);
    chk("t1_done_once", done_cnt - d0, 32'd1);
    chk("t1_bytes_left", exp_bytes.size(), 32'd0);
    chk("t1_ws_hold", {25'b0, words_sent}, 32'd2);

    // 2: nine words into the memory model
    d0 = done_cnt;
    queue_words(9, 16'h1000, 16'h0111);
    exp_ws.push_back(9); exp_err.push_back(0);
    pulse_start(9);
    wait_done(d0, 1000, "t2");
    for (int i = 0; i < 9; i++) chk("t2_mem_word", mem[i], 16'h1000 + 16'(i) * 16'h0111);
    chk("t2_ptr", ptr, 32'd9);

    // 3a: count 0 -> done two cycles after start, no clear, no strobe
    d0 = done_cnt; c0 = clr_seen; s0 = strobe_cnt;
    exp_ws.push_back(0); exp_err.push_back(0);
    pulse_start(0);
    #1;
    chk("t3a_busy", {31'b0, busy}, 32'd1);
    chk("t3a_done_early", {31'b0, done}, 32'd0);
    @(negedge clk);
    #1;
    chk("t3a_done", {31'b0, done}, 32'd1);
    chk("t3a_busy_low", {31'b0, busy}, 32'd0);
    chk("t3a_no_clear", clr_seen - c0, 32'd0);
    chk("t3a_no_strobe", strobe_cnt - s0, 32'd0);

    // 3b: count 70 clamps to 64, err flagged
    d0 = done_cnt; s0 = strobe_cnt;
    queue_words(64, 16'h8000, 16'h0203);
    exp_ws.push_back(64); exp_err.push_back(1);
    pulse_start(70);
    wait_done(d0, 3000, "t3b");
    chk("t3b_err", {31'b0, err_count}, 32'd1);
    chk("t3b_strobes", strobe_cnt - s0, 32'd128);
    chk("t3b_src_empty", src_q.size(), 32'd0);
    chk("t3b_ready_low", {31'b0, word_ready}, 32'd0);
    chk("t3b_ptr", ptr, 32'd64);

    // 4: source stalls 20 cycles after the first word
    d0 = done_cnt; s0 = strobe_cnt;
    queue_words(3, 16'hC0DE, 16'h1357);
    exp_ws.push_back(3); exp_err.push_back(0);
    pulse_start(3);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (src_q.size() == 2) ok = 1'b1;
    end
    chk("t4_first_accept", {31'b0, ok}, 32'd1);
    stall = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (word_ready) ok = 1'b1;
    end
    chk("t4_back_to_wait", {31'b0, ok}, 32'd1);
    bad_btn = 0; bad_rdy = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (button) bad_btn++;
      if (!word_ready) bad_rdy++;
    end
    chk("t4_stall_button_low", bad_btn, 32'd0);
    chk("t4_stall_ready_held", bad_rdy, 32'd0);
    chk("t4_stall_strobes", strobe_cnt - s0, 32'd2);
    stall = 1'b0;
    wait_done(d0, 500, "t4");
    chk("t4_strobes", strobe_cnt - s0, 32'd6);
    for (int i = 0; i < 3; i++) chk("t4_mem_word", mem[i], 16'hC0DE + 16'(i) * 16'h1357);

    // 5: reset during STROBE_LO of word 3, then reload
    s0 = strobe_cnt;
    queue_words(5, 16'hA5A0, 16'h1111);
    exp_ws.push_back(5); exp_err.push_back(0);
    pulse_start(5);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (strobe_cnt - s0 >= 6) ok = 1'b1;
    end
    chk("t5_reached_strobe6", {31'b0, ok}, 32'd1);
    chk("t5_in_strobe", {31'b0, button}, 32'd1);
    #1;
    reset = 1'b1;
    src_q.delete(); exp_bytes.delete(); exp_ws.delete(); exp_err.delete();
    #1;
    chk("t5_rst_button", {31'b0, button}, 32'd0);
    chk("t5_rst_mem_reset", {31'b0, mem_reset}, 32'd0);
    chk("t5_rst_busy", {31'b0, busy}, 32'd0);
    chk("t5_rst_words_sent", {25'b0, words_sent}, 32'd0);
    chk("t5_rst_instruction", {24'b0, instruction}, 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    d0 = done_cnt;
    queue_words(5, 16'hA5A0, 16'h1111);
    exp_ws.push_back(5); exp_err.push_back(0);
    pulse_start(5);
    wait_done(d0, 800, "t5");
    for (int i = 0; i < 5; i++) chk("t5_mem_word", mem[i], 16'hA5A0 + 16'(i) * 16'h1111);
    chk("t5_ptr", ptr, 32'd5);

    // 6: start pulses while busy are ignored
    d0 = done_cnt; s0 = strobe_cnt;
    queue_words(3, 16'h1357, 16'h2468);
    exp_ws.push_back(3); exp_err.push_back(0);
    pulse_start(3);
    for (int i = 0; i < 100 && strobe_cnt == s0; i++) @(negedge clk);
    pulse_start(70);
    #1;
    chk("t6_err_unchanged", {31'b0, err_count}, 32'd0);
    chk("t6_still_busy", {31'b0, busy}, 32'd1);
    pulse_start(0);
    #1 chk("t6_busy_after_zero", {31'b0, busy}, 32'd1);
    wait_done(d0, 500, "t6");
    repeat (5) @(negedge clk);
    #1;
    chk("t6_done_once", done_cnt - d0, 32'd1);
    chk("t6_ws_hold", {25'b0, words_sent}, 32'd3);
    chk("t6_ptr", ptr, 32'd3);
    for (int i = 0; i < 3; i++) begin
      w = 16'h1357 + 16'(i) * 16'h2468;
      chk("t6_mem_word", mem[i], w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
